// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with a 2-entry buffer,
// decode stall back-pressure and redirect flush with stale-response discard.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, target, resp_pc;
  logic [31:0] buf_pc [2];
  logic [31:0] buf_instr [2];
  logic [1:0] count, count_nxt;
  logic rd_ptr, wr_ptr, discard, push, bypass, wr, rd;
  assign target = redirect_pc & 32'hFFFF_FFFC;
  // fetch_pc already advanced on gnt, so the outstanding response belongs to fetch_pc-4
  assign resp_pc = fetch_pc - 32'd4;
  assign push = state == WAIT && imem_rvalid && !discard && !redirect_valid;
  assign bypass = push && count == 2'd0 && !stall;
  assign wr = push && !bypass;
  assign rd = count != 2'd0 && !stall && !redirect_valid;
  assign count_nxt = redirect_valid ? 2'd0 : count + {1'b0, wr} - {1'b0, rd};
  assign imem_req = state == REQ;
  assign imem_addr = fetch_pc;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = (redirect_valid || count != 2'd2) ? REQ : IDLE;
    else if (state == REQ) state_nxt = imem_gnt ? WAIT : REQ;
    else if (imem_rvalid) state_nxt = count_nxt == 2'd2 ? IDLE : REQ;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      buf_pc[wr_ptr] <= resp_pc;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      discard <= 1'b0;
      count <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      pc_out <= 32'd0;
      instr_out <= NOP_INSTR;
      valid_out <= 1'b0;
    end else begin
      count <= count_nxt;
      if (redirect_valid) fetch_pc <= target;
      else if (state == REQ && imem_gnt) fetch_pc <= fetch_pc + 32'd4;
      // a request already accepted but not yet answered must have its response dropped
      if (redirect_valid) discard <= (state == WAIT && !imem_rvalid) || (state == REQ && imem_gnt);
      else if (state == WAIT && imem_rvalid) discard <= 1'b0;
      if (redirect_valid) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (wr) wr_ptr <= ~wr_ptr;
        if (rd) rd_ptr <= ~rd_ptr;
      end
      if (redirect_valid) begin
        instr_out <= NOP_INSTR;
        valid_out <= 1'b0;
      end else if (!stall) begin
        if (rd) begin
          pc_out <= buf_pc[rd_ptr];
          instr_out <= buf_instr[rd_ptr];
        end else if (bypass) begin
          pc_out <= resp_pc;
          instr_out <= imem_rdata;
        end else instr_out <= NOP_INSTR;
        valid_out <= rd || bypass;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run checked by a
// queue scoreboard holding the expected sequential PC stream.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, reset_n = 0, stall = 0, redirect_valid = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, valid_out;
  logic [31:0] imem_addr, pc_out, instr_out;
  logic req2, valid2, rv2 = 0;
  logic [31:0] addr2, pc2, instr2, rd2 = 0;
  int checks = 0, errors = 0, seen = 0, nresp = 0;
  logic mon_en = 0, auto_mem = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] q2[$];
  logic [31:0] prev_pc = 0, prev_instr = 0;
  logic prev_valid = 0;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset_n(reset_n), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'd0), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(1'b1), .imem_rvalid(rv2), .imem_rdata(rd2),
    .pc_out(pc2), .instr_out(instr2), .valid_out(valid2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // 1-cycle memory for the wrap-around instance
  initial forever begin
    logic n;
    logic [31:0] a;
    @(posedge clk);
    n = req2;
    a = addr2;
    if (reset_n && req2 && q2.size() < 3) q2.push_back(addr2);
    @(negedge clk);
    rv2 = n;
    rd2 = mem_word(a);
  end

  // random-phase memory: record accepted requests
  always @(posedge clk)
    if (auto_mem && reset_n && imem_req && imem_gnt) pend_q.push_back(imem_addr);

  // monitor: compares every freshly loaded output against the scoreboard
  initial forever begin
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (mon_en && reset_n) begin
      if (redirect_valid) begin
        check("redir_valid", {31'd0, valid_out}, 32'd0);
        check("redir_instr", instr_out, NOP);
        check("redir_pc", pc_out, prev_pc);
      end else if (stall) begin
        check("stall_pc", pc_out, prev_pc);
        check("stall_instr", instr_out, prev_instr);
        check("stall_valid", {31'd0, valid_out}, {31'd0, prev_valid});
      end else if (valid_out) begin
        seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc %h expected none", pc_out);
        end else begin
          e = exp_q.pop_front();
          if (exp_q.size() > 0) exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
          else exp_q.push_back(e + 32'd4);
          check("stream_pc", pc_out, e);
          check("stream_instr", instr_out, mem_word(e));
        end
      end else begin
        check("empty_instr", instr_out, NOP);
        check("empty_pc", pc_out, prev_pc);
      end
    end
    prev_pc = pc_out;
    prev_instr = instr_out;
    prev_valid = valid_out;
  end

  initial begin
    logic pending, n_pend;
    logic [31:0] paddr, n_addr;
    repeat (2) tick;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_instr", instr_out, NOP);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    reset_n = 1;
    tick;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    imem_gnt = 1;
    tick;
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'h0050_0093;
    tick;
    imem_rvalid = 0;
    check("bypass_valid", {31'd0, valid_out}, 32'd1);
    check("bypass_pc", pc_out, 32'd0);
    check("bypass_instr", instr_out, 32'h0050_0093);
    check("next_addr", imem_addr, 32'd4);
    // stall with a 1-cycle memory: buffer fills then fetching stops
    stall = 1;
    pending = 0;
    paddr = 0;
    repeat (6) begin
      imem_gnt = 1;
      imem_rvalid = pending;
      imem_rdata = mem_word(paddr);
      if (pending) nresp++;
      n_pend = imem_req;
      n_addr = imem_addr;
      tick;
      pending = n_pend;
      paddr = n_addr;
      check("hold_pc", pc_out, 32'd0);
      check("hold_instr", instr_out, 32'h0050_0093);
    end
    check("stall_resp_count", nresp, 2);
    check("stall_req_off", {31'd0, imem_req}, 32'd0);
    imem_gnt = 0;
    imem_rvalid = 0;
    stall = 0;
    tick;
    check("drain0_pc", pc_out, 32'd4);
    check("drain0_instr", instr_out, mem_word(32'd4));
    tick;
    check("drain1_pc", pc_out, 32'd8);
    check("drain1_valid", {31'd0, valid_out}, 32'd1);
    tick;
    check("drain2_valid", {31'd0, valid_out}, 32'd0);
    check("drain2_instr", instr_out, NOP);
    // gnt held low; redirect while request pending
    for (int i = 0; i < 6; i++) begin
      check("gntlow_req", {31'd0, imem_req}, 32'd1);
      check("gntlow_addr", imem_addr, i >= 3 ? 32'h200 : 32'hC);
      redirect_valid = (i == 2);
      redirect_pc = 32'h203;
      tick;
    end
    redirect_valid = 0;
    check("redir_nop", instr_out, NOP);
    check("redir_pc_keep", pc_out, 32'd8);
    // redirect while waiting: stale response dropped
    imem_gnt = 1;
    tick;
    imem_gnt = 0;
    redirect_valid = 1;
    redirect_pc = 32'h100;
    tick;
    redirect_valid = 0;
    check("wait_redir_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1;
    imem_rdata = mem_word(32'h200);
    tick;
    imem_rvalid = 0;
    check("stale_drop_valid", {31'd0, valid_out}, 32'd0);
    check("stale_drop_req", {31'd0, imem_req}, 32'd1);
    check("stale_drop_addr", imem_addr, 32'h100);
    imem_gnt = 1;
    tick;
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = mem_word(32'h100);
    tick;
    imem_rvalid = 0;
    check("target_valid", {31'd0, valid_out}, 32'd1);
    check("target_pc", pc_out, 32'h100);
    check("target_instr", instr_out, mem_word(32'h100));
    // asynchronous reset mid-transaction, stale response after release
    imem_gnt = 1;
    tick;
    imem_gnt = 0;
    #2 reset_n = 0;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_valid", {31'd0, valid_out}, 32'd0);
    check("async_pc", pc_out, 32'd0);
    check("async_instr", instr_out, NOP);
    tick;
    reset_n = 1;
    imem_rvalid = 1;
    imem_rdata = 32'hDEAD_BEEF;
    tick;
    tick;
    imem_rvalid = 0;
    check("postrst_valid", {31'd0, valid_out}, 32'd0);
    check("postrst_instr", instr_out, NOP);
    check("postrst_req", {31'd0, imem_req}, 32'd1);
    check("postrst_addr", imem_addr, 32'd0);
    // randomized run against the scoreboard
    @(negedge clk);
    reset_n = 0;
    pend_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
    @(negedge clk);
    reset_n = 1;
    mon_en = 1;
    auto_mem = 1;
    repeat (3000) begin
      @(negedge clk);
      stall = $urandom_range(0, 3) == 0;
      imem_gnt = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 40) == 0;
      if (redirect_valid) begin
        redirect_pc = $urandom;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back((redirect_pc & 32'hFFFF_FFFC) + 32'(4 * i));
      end
      if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        imem_rvalid = 1;
        imem_rdata = mem_word(pend_q.pop_front());
      end else begin
        imem_rvalid = 0;
        imem_rdata = $urandom;
      end
    end
    @(negedge clk);
    mon_en = 0;
    auto_mem = 0;
    stall = 0;
    redirect_valid = 0;
    imem_rvalid = 0;
    check("progress", {31'd0, seen > 100}, 32'd1);
    check("wrap_count", q2.size(), 3);
    if (q2.size() == 3) begin
      check("wrap_addr0", q2[0], 32'hFFFF_FFF8);
      check("wrap_addr1", q2[1], 32'hFFFF_FFFC);
      check("wrap_addr2", q2[2], 32'h0000_0000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
